dm_core_data_router: RTL

//  Address-decoding router on the Ibex data port of the datamover test system.

---
 rtl/dm_router_pkg.sv | 15 +
 rtl/dm_router_tgt_fifo.sv | 58 +++++
 rtl/dm_core_data_router.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dm_router_pkg.sv
// Shared types and constants for the core data-port router.
package dm_router_pkg;

  typedef enum logic [2:0] {
    TGT_PERIPH = 3'd0,
    TGT_STACK  = 3'd1,
    TGT_MBOX   = 3'd2,
    TGT_TCDM   = 3'd3,
    TGT_ERR    = 3'd4
  } target_e;

  localparam logic [3:0] MBOX_EXIT_OFF = 4'h0;
  localparam logic [3:0] MBOX_CHAR_OFF = 4'h4;

endpackage

// File: rtl/dm_router_tgt_fifo.sv
// In-flight target FIFO: remembers which target owns each outstanding request.
module dm_router_tgt_fifo
  import dm_router_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  target_e data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output target_e head_o,
  output target_e tail_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  target_e            mem_q [DEPTH];
  target_e            tail_q;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = tail_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Circular storage, pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= TGT_PERIPH;
      tail_q   <= TGT_PERIPH;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        tail_q          <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dm_core_data_router.sv
// Routes core data requests to HWPE periph / stack / TCDM / mailbox / error sink
// and returns responses strictly in request order.
module dm_core_data_router
  import dm_router_pkg::*;
#(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter logic [11:0] STACK_PREFIX       = 12'h1c0,
  parameter logic [7:0]  MBOX_PREFIX        = 8'h80,
  parameter int unsigned MAX_OUTSTANDING    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        periph_req_o,
  output logic [31:0] periph_add_o,
  output logic        periph_wen_o,
  output logic [3:0]  periph_be_o,
  output logic [31:0] periph_data_o,
  input  logic        periph_gnt_i,
  input  logic [31:0] periph_r_data_i,
  input  logic        periph_r_valid_i,
  output logic        stack_req_o,
  output logic [31:0] stack_add_o,
  output logic        stack_wen_o,
  output logic [3:0]  stack_be_o,
  output logic [31:0] stack_data_o,
  input  logic        stack_gnt_i,
  input  logic [31:0] stack_r_data_i,
  input  logic        stack_r_valid_i,
  output logic        tcdm_req_o,
  output logic [31:0] tcdm_add_o,
  output logic        tcdm_wen_o,
  output logic [3:0]  tcdm_be_o,
  output logic [31:0] tcdm_data_o,
  input  logic        tcdm_gnt_i,
  input  logic [31:0] tcdm_r_data_i,
  input  logic        tcdm_r_valid_i,
  output logic [31:0] exit_code_o,
  output logic        exit_valid_o,
  output logic [7:0]  char_o,
  output logic        char_valid_o,
  output logic        protocol_err_o
);

  target_e     tgt_sel, fifo_head, fifo_tail;
  logic        fifo_full, fifo_empty, blocked, req_ok, local_gnt;
  logic [3:0]  mbox_off;
  logic        unexpected;

  logic        lrsp_valid_q, lrsp_valid_d, lrsp_err_q, lrsp_err_d;
  logic [31:0] lrsp_rdata_q, lrsp_rdata_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        exit_valid_q, exit_valid_d;
  logic [7:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d;
  logic        perr_q, perr_d;

  assign mbox_off = data_addr_i[3:0];

  // Address decode in priority order.
  always_comb begin
    tgt_sel = TGT_ERR;
    if (data_addr_i[HWPE_ADDR_BASE_BIT])                                    tgt_sel = TGT_PERIPH;
    else if (data_addr_i[31:20] == STACK_PREFIX && data_addr_i[19:18] == 2'b01) tgt_sel = TGT_STACK;
    else if (data_addr_i[31:24] == MBOX_PREFIX)                             tgt_sel = TGT_MBOX;
    else if (data_addr_i[31:24] != 8'h00)                                   tgt_sel = TGT_TCDM;
  end

  // A new request may only follow outstanding ones to the same target.
  assign blocked = fifo_full || (!fifo_empty && tgt_sel != fifo_tail);
  assign req_ok  = data_req_i && !blocked;

  assign periph_req_o  = req_ok && (tgt_sel == TGT_PERIPH);
  assign stack_req_o   = req_ok && (tgt_sel == TGT_STACK);
  assign tcdm_req_o    = req_ok && (tgt_sel == TGT_TCDM);
  assign local_gnt     = req_ok && (tgt_sel == TGT_MBOX || tgt_sel == TGT_ERR);
  assign data_gnt_o    = (periph_req_o && periph_gnt_i) || (stack_req_o && stack_gnt_i) ||
                         (tcdm_req_o && tcdm_gnt_i) || local_gnt;

  assign periph_add_o  = data_addr_i;
  assign periph_wen_o  = ~data_we_i;
  assign periph_be_o   = data_be_i;
  assign periph_data_o = data_wdata_i;
  assign stack_add_o   = data_addr_i;
  assign stack_wen_o   = ~data_we_i;
  assign stack_be_o    = data_be_i;
  assign stack_data_o  = data_wdata_i;
  assign tcdm_add_o    = data_addr_i;
  assign tcdm_wen_o    = ~data_we_i;
  assign tcdm_be_o     = data_be_i;
  assign tcdm_data_o   = data_wdata_i;

  dm_router_tgt_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (data_req_i && data_gnt_o),
    .data_i  (tgt_sel),
    .pop_i   (data_rvalid_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail)
  );

  // Response mux: only the head target may answer the core.
  always_comb begin
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    data_rdata_o  = '0;
    if (!fifo_empty) begin
      unique case (fifo_head)
        TGT_PERIPH: begin data_rvalid_o = periph_r_valid_i; data_rdata_o = periph_r_data_i; end
        TGT_STACK:  begin data_rvalid_o = stack_r_valid_i;  data_rdata_o = stack_r_data_i;  end
        TGT_TCDM:   begin data_rvalid_o = tcdm_r_valid_i;   data_rdata_o = tcdm_r_data_i;   end
        default:    begin
          data_rvalid_o = lrsp_valid_q;
          data_err_o    = lrsp_valid_q && lrsp_err_q;
          data_rdata_o  = lrsp_rdata_q;
        end
      endcase
      if (!data_rvalid_o) data_rdata_o = '0;
    end
  end

  assign unexpected = (periph_r_valid_i && (fifo_empty || fifo_head != TGT_PERIPH)) ||
                      (stack_r_valid_i  && (fifo_empty || fifo_head != TGT_STACK))  ||
                      (tcdm_r_valid_i   && (fifo_empty || fifo_head != TGT_TCDM));

  // Next state of the local (mailbox/error) response and mailbox registers.
  always_comb begin
    lrsp_valid_d = local_gnt;
    lrsp_err_d   = local_gnt && (tgt_sel == TGT_ERR);
    lrsp_rdata_d = (local_gnt && tgt_sel == TGT_MBOX && !data_we_i && mbox_off == MBOX_EXIT_OFF)
                   ? exit_code_q : '0;
    exit_code_d  = exit_code_q;
    exit_valid_d = exit_valid_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    perr_d       = perr_q || unexpected;
    if (local_gnt && tgt_sel == TGT_MBOX && data_we_i) begin
      if (mbox_off == MBOX_EXIT_OFF) begin
        exit_code_d  = data_wdata_i;
        exit_valid_d = 1'b1;
      end
      if (mbox_off == MBOX_CHAR_OFF) begin
        char_d       = data_wdata_i[7:0];
        char_valid_d = 1'b1;
      end
    end
  end

  // Local response, mailbox and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lrsp_valid_q <= 1'b0;
      lrsp_err_q   <= 1'b0;
      lrsp_rdata_q <= '0;
      exit_code_q  <= '0;
      exit_valid_q <= 1'b0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      lrsp_valid_q <= lrsp_valid_d;
      lrsp_err_q   <= lrsp_err_d;
      lrsp_rdata_q <= lrsp_rdata_d;
      exit_code_q  <= exit_code_d;
      exit_valid_q <= exit_valid_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      perr_q       <= perr_d;
    end
  end

  assign exit_code_o    = exit_code_q;
  assign exit_valid_o   = exit_valid_q;
  assign char_o         = char_q;
  assign char_valid_o   = char_valid_q;
  assign protocol_err_o = perr_q;

endmodule
